// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Holds the FSM state encoding, shift-type codes and step sizing.
package shift_pkg;

    localparam int SHIFT_WIDTH = 16;
    localparam int MULTI_STEP  = 4;
    localparam int STEP_W      = 3;

    localparam logic SHIFT_LOGICAL = 1'b1;
    localparam logic SHIFT_ARITH   = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of a WIDTH value by 1..MULTI_STEP bits.
// Left fills 0; right fills 0 (logical) or the MSB (arithmetic).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0]  din,
    input  logic              dir_right,
    input  logic              shift_type,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  dout
);

    always_comb begin
        dout = din << step;
        if (dir_right) begin
            if (shift_type == SHIFT_LOGICAL) begin
                dout = din >> step;
            end else begin
                dout = $unsigned($signed(din) >>> step);
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter: signed amount, >0 left, <0 right, clamped to WIDTH.
// Latency k+1 cycles (ceil(k/4)+1 with SHIFT_SEQ_MULTI_EN); starts during busy are dropped.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH     = SHIFT_WIDTH,
    parameter int CNT_WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] amount,
    input  logic             shift_type,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0]     FULL_MAG = WIDTH'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(WIDTH);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic                 dir_q, dir_d;
    logic                 type_q, type_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [WIDTH-1:0]     mag;
    logic [CNT_WIDTH-1:0] clamp;
    logic [STEP_W-1:0]    step;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic [WIDTH-1:0]     step_out;

    // 16'h8000 negates to itself, which as unsigned still clamps to WIDTH.
    always_comb begin
        mag   = amount[WIDTH-1] ? (~amount + WIDTH'(1)) : amount;
        clamp = (mag >= FULL_MAG) ? FULL_CNT : mag[CNT_WIDTH-1:0];
    end

`ifdef SHIFT_SEQ_MULTI_EN
    always_comb begin
        step = (count_q < CNT_WIDTH'(MULTI_STEP)) ? count_q[STEP_W-1:0] : STEP_W'(MULTI_STEP);
    end
`else
    always_comb begin
        step = STEP_W'(1);
    end
`endif

    assign cnt_dec = count_q - {{(CNT_WIDTH-STEP_W){1'b0}}, step};

    shift_step #(.WIDTH(WIDTH)) u_step (
        .din        (work_q),
        .dir_right  (dir_q),
        .shift_type (type_q),
        .step       (step),
        .dout       (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        dir_d    = dir_q;
        type_d   = type_q;
        count_d  = count_q;
        busy_d   = (state_q == SHIFT);
        done_d   = (state_q == DONE);
        result_d = (state_q == DONE) ? work_q : result_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = src;
                    dir_d   = amount[WIDTH-1];
                    type_d  = shift_type;
                    count_d = clamp;
                    state_d = (clamp != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d  = step_out;
                count_d = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            dir_q    <= 1'b0;
            type_q   <= SHIFT_ARITH;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            dir_q    <= dir_d;
            type_q   <= type_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a timing/arith model queues expected
// done edges and results; a negedge monitor compares busy, done and result.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] amount;
    logic        shift_type;
    logic        busy;
    logic        done;
    logic [15:0] result;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .amount     (amount),
        .shift_type (shift_type),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    typedef struct {
        int unsigned due;
        logic [15:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_n  = 0;
    int unsigned free_at = 0;
    int unsigned busy_lo = 1;
    int unsigned busy_hi = 0;
    logic [15:0] held    = 16'h0;
    bit          mon_en  = 1'b0;
    int          checks  = 0;
    int          errors  = 0;

    function automatic logic [15:0] ref_shift(input logic [15:0] s, input logic [15:0] a,
                                              input logic t, output int k);
        int          amt;
        logic [31:0] wide;
        amt = int'($signed(a));
        k   = (amt >= 0) ? amt : -amt;
        if (k > 16) k = 16;
        if (amt >= 0)
            wide = {16'h0, s} << k;
        else if (t)
            wide = {16'h0, s} >> k;
        else
            wide = $unsigned($signed({{16{s[15]}}, s}) >>> k);
        return wide[15:0];
    endfunction

    function automatic int shift_cycles(input int k);
`ifdef SHIFT_SEQ_MULTI_EN
        return (k + 3) / 4;
`else
        return k;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, expv, edge_n);
        end
    endtask

    task automatic cyc(input logic st, input logic [15:0] s, input logic [15:0] a,
                       input logic t, input logic r);
        logic [15:0] res;
        int          k;
        int          n;
        start = st; src = s; amount = a; shift_type = t; reset = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            exp_q.delete();
            held    = 16'h0;
            busy_lo = 1;
            busy_hi = 0;
            free_at = edge_n + 1;
        end else if (st && edge_n >= free_at) begin
            res = ref_shift(s, a, t, k);
            n   = shift_cycles(k);
            exp_q.push_back('{due: edge_n + n + 1, res: res});
            busy_lo = edge_n + 1;
            busy_hi = edge_n + n;
            free_at = edge_n + n + 1;
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic op(input logic [15:0] s, input logic [15:0] a, input logic t);
        while (edge_n + 1 < free_at) idle();
        cyc(1'b1, s, a, t, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = (edge_n >= busy_lo) && (edge_n <= busy_hi);
            exp_done = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
            check("busy", {15'h0, busy}, {15'h0, exp_busy});
            check("done", {15'h0, done}, {15'h0, exp_done});
            if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
                held = exp_q[0].res;
                void'(exp_q.pop_front());
            end
            check("result", result, held);
        end
    end

    initial begin
        int r;
        int amt;
        logic [15:0] a;
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 16'h1111, 16'h0002, 1'b0, 1'b1);
        mon_en = 1'b1;

        op(16'hFFFF, 16'hFFFF, 1'b1);
        op(16'h0001, 16'h0003, 1'b0);
        op(16'h8000, 16'hFFFD, 1'b0);
        op(16'h8000, 16'hFFFD, 1'b1);
        idle(); idle(); idle();
        op(16'h1234, 16'h0000, 1'b0);
        op(16'h8001, 16'hFFE0, 1'b0);
        op(16'h00FF, 16'h0008, 1'b1);
        idle(); idle();
        cyc(1'b1, 16'hAAAA, 16'h0002, 1'b0, 1'b0);
        op(16'h5555, 16'hFFFC, 1'b0);
        op(16'h8421, 16'h8000, 1'b0);
        op(16'h8421, 16'h8000, 1'b1);
        op(16'hBEEF, 16'h0010, 1'b0);
        op(16'h8765, 16'hFFF0, 1'b0);
        op(16'h8765, 16'h000F, 1'b1);
        op(16'h0123, 16'h0009, 1'b1);
        op(16'hF0F0, 16'h0005, 1'b1);
        idle();
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(); idle(); idle(); idle(); idle(); idle();

        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    amt = int'($urandom_range(0, 40)) - 20;
                    a   = 16'(amt);
                end
                3:       a = 16'($urandom);
                4:       a = 16'h8000;
                default: a = 16'h7FFF;
            endcase
            cyc(r < 40, 16'($urandom), a, 1'($urandom), r == 99);
        end

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending ops expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the 16-bit datapath. It accepts a register operand and a signed shift amount in register form: positive shifts left, negative shifts right. It then produces the shifted result iteratively, one bit per cycle by default. The block sits between the register-file read stage and ALU writeback, and gives arbitrary-distance logical and arithmetic shifts to instructions that the single-step shifter cannot complete in one pass.

## Interface
- WIDTH, 16, operand and result width.
- CNT_WIDTH, 5, width of the internal remaining-count register; it must hold the value WIDTH.
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- src  input  WIDTH  operand.
- amount  input  WIDTH  signed two's-complement shift amount (>0 left, <0 right, 0 none).
- shift_type  input  1  1 = logical, 0 = arithmetic.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  shifted value; held until the next accepted start.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE or DONE with start=1:**
  - Latch src into the working register.
  - Latch direction (amount[WIDTH-1]) and shift_type.
  - Set count = min(|amount|, WIDTH).
  - Go to SHIFT if count>0, else go to DONE.
- **IDLE or DONE with start=0:**
  - DONE goes to IDLE.
  - IDLE stays in IDLE.
- **SHIFT:** each cycle shift the working register by one bit and decrement count. Go to DONE when count reaches 0 after the step.
- **DONE:** done=1 and result=working register. A start in DONE is accepted, so back-to-back operation has no idle bubble.
- **Shift rules:**
  - Left shift always fills with 0 for both types.
  - Logical right fills with 0.
  - Arithmetic right fills with the latched operand's MSB.
- **Saturation:** magnitudes of WIDTH or more clamp to WIDTH.
  - Left shift gives 0.
  - Logical right gives 0.
  - Arithmetic right gives all copies of the sign bit.
  - amount=16'h8000 (magnitude is not representable) clamps to WIDTH, right shift.
- **Input changes:** start while busy=1 is ignored. src, amount and shift_type may change freely after acceptance.
- **Reset:**
  - state=IDLE.
  - busy=0, done=0, result=0, count=0.
  - Reset mid-operation abandons the shift with no done pulse.
- result updates only on entry to DONE. During SHIFT it keeps the previous operation's value.

## Timing
- Start accepted at edge N. With k = clamped magnitude:
  - done=1 during the cycle following edge N+k+1.
  - busy=1 during the cycles following edges N+1 … N+k.
- amount=0: done one cycle after acceptance; result=src.
- Throughput is one operation per k+1 cycles with back-to-back starts.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- SHIFT_SEQ_MULTI_EN defined:
  - Each SHIFT cycle shifts by min(count, 4) bits and subtracts that step from count.
  - Latency becomes ceil(k/4)+1 cycles.
  - Fill and saturation rules are unchanged.
- Undefined: exactly one bit per SHIFT cycle, as described above.

## Structure
- **Package shift_pkg:**
  - SHIFT_LOGICAL=1'b1 and SHIFT_ARITH=1'b0.
  - State enum typedef (IDLE, SHIFT, DONE).
  - Default WIDTH constant.
  - Step-size constant MULTI_STEP=4.
- **Sub-module shift_step:** combinational shift of a WIDTH value by a step of 1..MULTI_STEP.
  - Inputs: direction, shift_type, step.
  - The same fill rules as above apply.
  - It is instantiated once in the SHIFT datapath.
- Everything else lives in shift_sequencer: FSM, count register, magnitude and clamp logic.

## Test plan
- src=16'hFFFF, amount=16'hFFFF (−1), logical → done 2 cycles after start, result=16'h7FFF.
- src=16'h0001, amount=16'h0003, arithmetic → busy for 3 cycles, result=16'h0008.
- src=16'h8000, amount=16'hFFFD (−3), arithmetic → result=16'hF000. Repeat with logical → 16'h1000.
- src=16'h1234, amount=0 → done 1 cycle after start, result=16'h1234, busy never high. Then src=16'h8001, amount=16'hFFE0 (−32), arithmetic → clamp to 16, result=16'hFFFF, 17-cycle latency.
- Start src=16'h00FF, amount=8, then pulse start with other operands mid-SHIFT → ignored, result=16'hFF00. Start again in the DONE cycle → accepted with no idle cycle.
- Assert reset during SHIFT → next cycle busy=0, done=0, result=0, and no done pulse follows. With SHIFT_SEQ_MULTI_EN, amount=9 → done 4 cycles after start.
